mem_access_master: RTL

- Initiator side of the CPU data-memory interface. Replaces direct combinational DPI reads/writes for loads and stores with a registered request/response master.
- Accepts one load/store request at a time from the multi-cycle core's execute stage.
- Drives an aligned 64-bit memory bus with read-enable / write-enable, byte mask and completion handshake.
- Returns a load result that is byte-extracted and sign- or zero-extended, or an error flag on misalignment or timeout.

---
 rtl/mem_access_master.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/mem_access_master.sv
// rtl/mem_access_master.sv - registered load/store master for the core data-memory bus
// One request in flight; bus outputs and response are registered, ready/valid decode from state.
module mem_access_master #(
  parameter int DATA_WIDTH = 64,
  parameter int TIMEOUT    = 255
) (
  input  logic                  iClock,
  input  logic                  iReset,
  input  logic                  iReqValid,
  output logic                  oReqReady,
  input  logic                  iReqWr,
  input  logic [DATA_WIDTH-1:0] iReqAddr,
  input  logic [DATA_WIDTH-1:0] iReqData,
  input  logic [7:0]            iReqLen,
  input  logic                  iReqSigned,
  output logic                  oRespValid,
  output logic [DATA_WIDTH-1:0] oRespData,
  output logic                  oRespErr,
  output logic                  oMemRdEn,
  output logic [DATA_WIDTH-1:0] oMemRdAddr,
  input  logic                  iMemRdValid,
  input  logic [DATA_WIDTH-1:0] iMemRdData,
  output logic                  oMemWrEn,
  output logic [DATA_WIDTH-1:0] oMemWrAddr,
  output logic [DATA_WIDTH-1:0] oMemWrData,
  output logic [7:0]            oMemWrMask,
  input  logic                  iMemWrAck
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, RESP} state_t;

  state_t                state, state_nx;
  logic [7:0]            cnt, cnt_nx;
  logic [2:0]            off, off_nx;
  logic [7:0]            len, len_nx;
  logic                  sgn, sgn_nx;
  logic                  wr, wr_nx;
  logic                  rd_en_nx, wr_en_nx, err_nx;
  logic [DATA_WIDTH-1:0] rd_addr_nx, wr_addr_nx, wr_data_nx, resp_nx;
  logic [7:0]            wr_mask_nx;
  logic                  aligned, done;
  logic [DATA_WIDTH-1:0] sh, ext;

  assign oReqReady  = (state == IDLE);
  assign oRespValid = (state == RESP);

  always_comb begin
    case (iReqLen)
      8'd1:    aligned = 1'b1;
      8'd2:    aligned = ~iReqAddr[0];
      8'd4:    aligned = (iReqAddr[1:0] == 2'b00);
      8'd8:    aligned = (iReqAddr[2:0] == 3'b000);
      default: aligned = 1'b0;
    endcase
  end

  // Lane-extract the load from the aligned word, then truncate and extend.
  assign sh = iMemRdData >> {off, 3'b000};
  always_comb begin
    case (len)
      8'd1:    ext = {{(DATA_WIDTH-8){sgn & sh[7]}},   sh[7:0]};
      8'd2:    ext = {{(DATA_WIDTH-16){sgn & sh[15]}}, sh[15:0]};
      8'd4:    ext = {{(DATA_WIDTH-32){sgn & sh[31]}}, sh[31:0]};
      default: ext = sh;
    endcase
  end

  assign done = wr ? iMemWrAck : iMemRdValid;

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    off_nx     = off;
    len_nx     = len;
    sgn_nx     = sgn;
    wr_nx      = wr;
    rd_en_nx   = oMemRdEn;
    wr_en_nx   = oMemWrEn;
    rd_addr_nx = oMemRdAddr;
    wr_addr_nx = oMemWrAddr;
    wr_data_nx = oMemWrData;
    wr_mask_nx = oMemWrMask;
    err_nx     = oRespErr;
    resp_nx    = oRespData;
    case (state)
      IDLE: begin
        if (iReqValid) begin
          off_nx = iReqAddr[2:0];
          len_nx = iReqLen;
          sgn_nx = iReqSigned;
          wr_nx  = iReqWr;
          cnt_nx = 8'd0;
          if (!aligned) begin
            state_nx = RESP;
            err_nx   = 1'b1;
            resp_nx  = '0;
          end else if (iReqWr) begin
            state_nx   = WR_WAIT;
            wr_en_nx   = 1'b1;
            wr_addr_nx = {iReqAddr[DATA_WIDTH-1:3], 3'b000};
            wr_data_nx = iReqData << {iReqAddr[2:0], 3'b000};
            wr_mask_nx = 8'(((16'd1 << iReqLen[3:0]) - 16'd1) << iReqAddr[2:0]);
          end else begin
            state_nx   = RD_WAIT;
            rd_en_nx   = 1'b1;
            rd_addr_nx = {iReqAddr[DATA_WIDTH-1:3], 3'b000};
          end
        end
      end
      RD_WAIT, WR_WAIT: begin
        // Completion wins over a timeout landing on the same edge.
        if (done) begin
          state_nx = RESP;
          rd_en_nx = 1'b0;
          wr_en_nx = 1'b0;
          err_nx   = 1'b0;
          resp_nx  = wr ? '0 : ext;
        end else if (cnt == 8'(TIMEOUT - 1)) begin
          state_nx = RESP;
          rd_en_nx = 1'b0;
          wr_en_nx = 1'b0;
          err_nx   = 1'b1;
          resp_nx  = '0;
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end
      RESP: begin
        state_nx = IDLE;
        cnt_nx   = 8'd0;
        err_nx   = 1'b0;
        resp_nx  = '0;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      off        <= 3'd0;
      len        <= 8'd0;
      sgn        <= 1'b0;
      wr         <= 1'b0;
      oMemRdEn   <= 1'b0;
      oMemWrEn   <= 1'b0;
      oMemRdAddr <= '0;
      oMemWrAddr <= '0;
      oMemWrData <= '0;
      oMemWrMask <= 8'd0;
      oRespErr   <= 1'b0;
      oRespData  <= '0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      off        <= off_nx;
      len        <= len_nx;
      sgn        <= sgn_nx;
      wr         <= wr_nx;
      oMemRdEn   <= rd_en_nx;
      oMemWrEn   <= wr_en_nx;
      oMemRdAddr <= rd_addr_nx;
      oMemWrAddr <= wr_addr_nx;
      oMemWrData <= wr_data_nx;
      oMemWrMask <= wr_mask_nx;
      oRespErr   <= err_nx;
      oRespData  <= resp_nx;
    end
  end

endmodule
